// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
// Main control FSM for the multi-cycle RV32I-subset datapath. Each
// instruction walks through FETCH, DECODE and then an opcode-specific
// sequence of execute, memory and writeback states. The FSM drives the
// datapath mux selects and write enables. It also produces the 2-bit
// ALU_op that the downstream ALU decoder combines with f3/f7.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset (forces FETCH)
//   op[6:0]     opcode from the instruction register
//   f3[2:0]     funct3 from the instruction register (branch resolution)
//   zero, lt    ALU flags, consumed only in the BRANCH cycle
//   PC_write    load PC from the result bus
//   adr_src     memory address select: 0 = PC, 1 = result bus
//   mem_write   data memory write enable
//   IR_write    latch instruction and old_PC
//   reg_write   register file write enable
//   result_src  00 ALU_out, 01 mem data, 10 ALU result, 11 immext
//   ALU_src_A   00 PC, 01 old_PC, 10 rs1
//   ALU_src_B   00 rs2, 01 immext, 10 constant 4
//   ALU_op      00 add, 01 sub, 10 R-type, 11 I-type
//   imm_src     000 I, 001 S, 010 B, 011 J, 100 U
//   illegal     one-cycle pulse in DECODE on an unsupported opcode
//   dbg_state   current FSM state, for observation only
// There are no handshakes: the controller advances one state per cycle.
module multi_cycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] f3,
   input  logic       zero,
   input  logic       lt,
   output logic       PC_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       IR_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] ALU_src_A,
   output logic [1:0] ALU_src_B,
   output logic [1:0] ALU_op,
   output logic [2:0] imm_src,
   output logic       illegal,
   output logic [3:0] dbg_state
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_JALR      = 4'd9,
      S_JAL       = 4'd10,
      S_BRANCH    = 4'd11,
      S_LUI       = 4'd12
   } state_t;

   state_t r_state;
   state_t w_next_state;
   logic   w_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   assign dbg_state = r_state;

   // Branch resolution; unsupported funct3 values never branch.
   always_comb begin
      w_taken = 1'b0;
      case (f3)
         3'b000:  w_taken = zero;
         3'b001:  w_taken = ~zero;
         3'b100:  w_taken = lt;
         3'b101:  w_taken = ~lt;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_next_state = S_FETCH;
      PC_write     = 1'b0;
      adr_src      = 1'b0;
      mem_write    = 1'b0;
      IR_write     = 1'b0;
      reg_write    = 1'b0;
      result_src   = 2'b00;
      ALU_src_A    = 2'b00;
      ALU_src_B    = 2'b00;
      ALU_op       = 2'b00;
      imm_src      = 3'b000;
      illegal      = 1'b0;

      // Immediate format follows the opcode in every state.
      case (op)
         OP_LW, OP_I, OP_JALR: imm_src = 3'b000;
         OP_SW:                imm_src = 3'b001;
         OP_BR:                imm_src = 3'b010;
         OP_JAL:               imm_src = 3'b011;
         OP_LUI:               imm_src = 3'b100;
         default:              imm_src = 3'b000;
      endcase

      case (r_state)
         S_FETCH: begin
            IR_write     = 1'b1;
            ALU_src_A    = 2'b00;
            ALU_src_B    = 2'b10;
            result_src   = 2'b10;
            PC_write     = 1'b1;
            w_next_state = S_DECODE;
         end
         S_DECODE: begin
            // ALU_out captures old_PC + imm as a speculative target.
            ALU_src_A = 2'b01;
            ALU_src_B = 2'b01;
            case (op)
               OP_LW, OP_SW: w_next_state = S_MEM_ADR;
               OP_R:         w_next_state = S_EXEC_R;
               OP_I:         w_next_state = S_EXEC_I;
               OP_BR:        w_next_state = S_BRANCH;
               OP_JAL:       w_next_state = S_JAL;
               OP_JALR:      w_next_state = S_JALR;
               OP_LUI:       w_next_state = S_LUI;
               default: begin
                  w_next_state = S_FETCH;
                  illegal      = 1'b1;
               end
            endcase
         end
         S_MEM_ADR: begin
            ALU_src_A    = 2'b10;
            ALU_src_B    = 2'b01;
            w_next_state = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            adr_src      = 1'b1;
            w_next_state = S_MEM_WB;
         end
         S_MEM_WB: begin
            result_src   = 2'b01;
            reg_write    = 1'b1;
            w_next_state = S_FETCH;
         end
         S_MEM_WRITE: begin
            adr_src      = 1'b1;
            mem_write    = 1'b1;
            w_next_state = S_FETCH;
         end
         S_EXEC_R: begin
            ALU_src_A    = 2'b10;
            ALU_src_B    = 2'b00;
            ALU_op       = 2'b10;
            w_next_state = S_ALU_WB;
         end
         S_EXEC_I: begin
            ALU_src_A    = 2'b10;
            ALU_src_B    = 2'b01;
            ALU_op       = 2'b11;
            w_next_state = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write    = 1'b1;
            w_next_state = S_FETCH;
         end
         S_JALR: begin
            // Overwrite ALU_out with rs1 + imm, then reuse the JAL state.
            ALU_src_A    = 2'b10;
            ALU_src_B    = 2'b01;
            w_next_state = S_JAL;
         end
         S_JAL: begin
            // PC takes the target from ALU_out while the ALU forms the
            // link value old_PC + 4 for the following writeback.
            PC_write     = 1'b1;
            ALU_src_A    = 2'b01;
            ALU_src_B    = 2'b10;
            w_next_state = S_ALU_WB;
         end
         S_BRANCH: begin
            ALU_src_A    = 2'b10;
            ALU_src_B    = 2'b00;
            ALU_op       = 2'b01;
            PC_write     = w_taken;
            w_next_state = S_FETCH;
         end
         S_LUI: begin
            result_src   = 2'b11;
            reg_write    = 1'b1;
            w_next_state = S_FETCH;
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase

      // A reset cycle must not commit any architectural state.
      if (rst) begin
         PC_write  = 1'b0;
         IR_write  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       zero;
  logic       lt;
  logic       PC_write, adr_src, mem_write, IR_write, reg_write, illegal;
  logic [1:0] result_src, ALU_src_A, ALU_src_B, ALU_op;
  logic [2:0] imm_src;
  logic [3:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .zero(zero), .lt(lt),
    .PC_write(PC_write), .adr_src(adr_src), .mem_write(mem_write),
    .IR_write(IR_write), .reg_write(reg_write), .result_src(result_src),
    .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .ALU_op(ALU_op),
    .imm_src(imm_src), .illegal(illegal), .dbg_state(dbg_state)
  );

  // Output vector order:
  // {PC_write, adr_src, mem_write, IR_write, reg_write,
  //  result_src, ALU_src_A, ALU_src_B, ALU_op, imm_src, illegal}
  typedef struct {
    logic [16:0] v;
    string       n;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic driving_done = 1'b0;

  function automatic logic [16:0] mk(
    input logic pcw, input logic adr, input logic memw, input logic irw,
    input logic regw, input logic [1:0] rs, input logic [1:0] a,
    input logic [1:0] b, input logic [1:0] aop, input logic [2:0] imm,
    input logic ill);
    return {pcw, adr, memw, irw, regw, rs, a, b, aop, imm, ill};
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle: drive inputs just after the rising edge, record what the
  // outputs must be during this cycle, then advance to the next edge.
  task automatic cyc(input logic r, input logic [6:0] o, input logic [2:0] f,
                     input logic z, input logic l, input logic [16:0] v,
                     input string n);
    exp_t e;
    rst  = r;
    op   = o;
    f3   = f;
    zero = z;
    lt   = l;
    e.v  = v;
    e.n  = n;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [6:0] o, input logic [2:0] f,
                              input logic z, input logic l,
                              input logic [2:0] imm, input string n);
    cyc(1'b0, o, f, z, l, mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,imm,0), {n, ".fetch"});
    cyc(1'b0, o, f, z, l, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,imm,0), {n, ".decode"});
  endtask

  task automatic alu_wb(input logic [6:0] o, input logic [2:0] imm, input string n);
    cyc(1'b0, o, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,imm,0), {n, ".alu_wb"});
  endtask

  task automatic do_r(input logic [6:0] o, input string n);
    fetch_decode(o, 3'b000, 1'b0, 1'b0, 3'b000, n);
    cyc(1'b0, o, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0), {n, ".exec_r"});
    alu_wb(o, 3'b000, n);
  endtask

  task automatic do_i(input string n);
    fetch_decode(7'b0010011, 3'b000, 1'b0, 1'b0, 3'b000, n);
    cyc(1'b0, 7'b0010011, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b11,3'b000,0), {n, ".exec_i"});
    alu_wb(7'b0010011, 3'b000, n);
  endtask

  task automatic do_lw(input string n);
    fetch_decode(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, n);
    cyc(1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), {n, ".mem_adr"});
    cyc(1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), {n, ".mem_read"});
    cyc(1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0), {n, ".mem_wb"});
  endtask

  task automatic do_sw(input string n);
    fetch_decode(7'b0100011, 3'b010, 1'b0, 1'b0, 3'b001, n);
    cyc(1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b001,0), {n, ".mem_adr"});
    cyc(1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0, mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,0), {n, ".mem_write"});
  endtask

  task automatic do_br(input logic [2:0] f, input logic z, input logic l,
                       input logic taken, input string n);
    fetch_decode(7'b1100011, f, z, l, 3'b010, n);
    cyc(1'b0, 7'b1100011, f, z, l, mk(taken,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0), {n, ".branch"});
  endtask

  task automatic do_jalr(input string n);
    fetch_decode(7'b1100111, 3'b000, 1'b0, 1'b0, 3'b000, n);
    cyc(1'b0, 7'b1100111, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), {n, ".jalr"});
    cyc(1'b0, 7'b1100111, 3'b000, 1'b0, 1'b0, mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b000,0), {n, ".jal"});
    alu_wb(7'b1100111, 3'b000, n);
  endtask

  task automatic do_jal(input string n);
    fetch_decode(7'b1101111, 3'b000, 1'b0, 1'b0, 3'b011, n);
    cyc(1'b0, 7'b1101111, 3'b000, 1'b0, 1'b0, mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b011,0), {n, ".jal"});
    alu_wb(7'b1101111, 3'b011, n);
  endtask

  task automatic do_lui(input string n);
    fetch_decode(7'b0110111, 3'b000, 1'b0, 1'b0, 3'b100, n);
    cyc(1'b0, 7'b0110111, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,1,2'b11,2'b00,2'b00,2'b00,3'b100,0), {n, ".lui"});
  endtask

  task automatic do_illegal(input string n);
    cyc(1'b0, 7'b1111111, 3'b000, 1'b0, 1'b0, mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), {n, ".fetch"});
    cyc(1'b0, 7'b1111111, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1), {n, ".decode"});
  endtask

  // lw interrupted by a two-cycle reset that starts in MEM_READ.
  task automatic do_reset_mid(input string n);
    fetch_decode(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, n);
    cyc(1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), {n, ".mem_adr"});
    cyc(1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), {n, ".rst_in_mem_read"});
    cyc(1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), {n, ".rst_fetch"});
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [16:0] act;
  assign act = {PC_write, adr_src, mem_write, IR_write, reg_write,
                result_src, ALU_src_A, ALU_src_B, ALU_op, imm_src, illegal};

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (act === e.v) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got %b expected %b (pcw adr memw irw regw rs A B aop imm ill)",
                   e.n, act, e.v);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; op = 7'b0000011; f3 = 3'b000; zero = 1'b0; lt = 1'b0;
    @(posedge clk);
    #1;
    // Power-on reset: FETCH values with every write enable held low.
    cyc(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "por.0");
    cyc(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "por.1");

    do_r(7'b0110011, "add");
    do_lw("lw");
    do_sw("sw");
    do_br(3'b000, 1'b1, 1'b0, 1'b1, "beq_taken");
    do_br(3'b001, 1'b1, 1'b0, 1'b0, "bne_not");
    do_br(3'b101, 1'b0, 1'b0, 1'b1, "bge_taken");
    do_br(3'b010, 1'b1, 1'b1, 1'b0, "f3_010_never");
    do_br(3'b100, 1'b0, 1'b1, 1'b1, "blt_taken");
    do_br(3'b101, 1'b0, 1'b1, 1'b0, "bge_not");
    do_br(3'b000, 1'b0, 1'b0, 1'b0, "beq_not");
    do_jalr("jalr");
    do_jal("jal");
    do_illegal("illegal");
    do_lui("lui");
    do_i("addi");
    do_reset_mid("rst_mid");
    do_r(7'b0110011, "add_after_rst");
    do_sw("sw_tail");
    driving_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    int waited;
    waited = 0;
    while (!driving_done && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    if (!driving_done) begin
      n_checks++;
      $display("FAIL stimulus_timeout: driving not done after %0d cycles", waited);
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Main control FSM for the multi-cycle RV32I-subset datapath. It walks each instruction through fetch, decode, execute, memory and writeback states and drives the datapath mux selects and write enables. It also produces the 2-bit ALU_op that the downstream ALU decoder turns into ALU_func together with f3/f7. It sits between the instruction register (op/f3 fields) plus ALU flags, and the datapath control inputs.

## Interface
- No parameters; all encodings are fixed.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  7  instruction opcode from IR
- f3  in  3  funct3 from IR; used only for branch resolution
- zero  in  1  ALU result == 0
- lt  in  1  signed A < B, valid while ALU performs SUB
- PC_write  out  1  load PC from result bus
- adr_src  out  1  memory address: 0 = PC, 1 = result bus
- mem_write  out  1  data memory write enable
- IR_write  out  1  latch instruction and old_PC
- reg_write  out  1  register file write enable
- result_src  out  2  00 ALU_out register, 01 memory data register, 10 ALU result direct, 11 immext
- ALU_src_A  out  2  00 PC, 01 old_PC, 10 rs1 register A
- ALU_src_B  out  2  00 rs2 register B, 01 immext, 10 constant 4
- ALU_op  out  2  00 ADD_ANYWAY, 01 SUB_ANYWAY, 10 R_TYPE, 11 I_TYPE
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- Supported opcodes:
  - R 0110011
  - I-ALU 0010011
  - lw 0000011
  - sw 0100011
  - branch 1100011
  - jal 1101111
  - jalr 1100111
  - lui 0110111
- imm_src is decoded combinationally from op in every state:
  - lw/I-ALU/jalr -> I
  - sw -> S
  - branch -> B
  - jal -> J
  - lui -> U
  - otherwise 000
- Outputs are Moore (state-only) unless noted. Unlisted outputs are 0 and ALU_op defaults to 00.
- FETCH: adr_src=0, IR_write=1, A=00, B=10, ALU_op=00, result_src=10, PC_write=1. Next: DECODE.
- DECODE: A=01, B=01, ALU_op=00; ALU_out captures old_PC+imm. Next state by opcode:
  - lw/sw -> MEM_ADR
  - R -> EXEC_R
  - I-ALU -> EXEC_I
  - branch -> BRANCH
  - jal -> JAL
  - jalr -> JALR
  - lui -> LUI
  - other -> FETCH, with illegal=1
- MEM_ADR: A=10, B=01, ALU_op=00. Next: MEM_READ if op=lw, else MEM_WRITE.
- MEM_READ: adr_src=1, result_src=00. Next: MEM_WB.
- MEM_WB: result_src=01, reg_write=1. Next: FETCH.
- MEM_WRITE: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
- EXEC_R: A=10, B=00, ALU_op=10. Next: ALU_WB.
- EXEC_I: A=10, B=01, ALU_op=11. Next: ALU_WB.
- ALU_WB: result_src=00, reg_write=1. Next: FETCH.
- JALR: A=10, B=01, ALU_op=00; ALU_out captures rs1+imm. Next: JAL.
- JAL: result_src=00, PC_write=1 (PC <- target in ALU_out); A=01, B=10, ALU_op=00, so ALU_out captures old_PC+4. Next: ALU_WB.
- BRANCH: A=10, B=00, ALU_op=01, result_src=00. Next: FETCH.
  - PC_write is Mealy and equals taken.
  - taken by f3: 000 beq = zero; 001 bne = !zero; 100 blt = lt; 101 bge = !lt; any other f3 = 0.
- LUI: result_src=11, reg_write=1. Next: FETCH.

## Timing
- Reset:
  - rst sampled high at an edge -> state = FETCH after that edge, regardless of current state.
  - This holds mid-instruction as well; the partial instruction is abandoned with no further writes.
- While rst=1, PC_write, IR_write, mem_write and reg_write are forced to 0.
- Other outputs show FETCH values (or the current state's values in the reset cycle itself); they have no architectural effect.
- First rising edge with rst=0 performs the first fetch.
- Cycles per instruction, FETCH to the next FETCH:
  - R/I-ALU: 4
  - lw: 5
  - sw: 4
  - branch: 3 (taken or not)
  - jal: 4
  - jalr: 5
  - lui: 3
  - illegal: 2
- op and f3 are sampled every cycle after FETCH, since IR is stable from DECODE onward.
- zero and lt are used only in the BRANCH cycle and are combinational from the datapath in that same cycle.
- illegal is high for exactly the DECODE cycle.

## Test plan
- rst=1 for 2 cycles asserted in the MEM_READ state, then released -> no write enables during reset; first cycle after release shows FETCH (IR_write=1, PC_write=1).
- op=0110011, R-type add -> states FETCH, DECODE, EXEC_R (ALU_op=10), ALU_WB (reg_write=1, result_src=00); back in FETCH on cycle 5.
- op=0000011, lw -> 5 cycles; MEM_READ shows adr_src=1; MEM_WB shows result_src=01, reg_write=1; imm_src=000 throughout. op=0100011, sw -> MEM_WRITE shows mem_write=1 for exactly 1 cycle; imm_src=001.
- op=1100011 with four cases -> PC_write=1 in BRANCH only when taken; ALU_op=01:
  - f3=000 (beq), zero=1 -> taken
  - f3=001 (bne), zero=1 -> not taken
  - f3=101 (bge), lt=0 -> taken
  - f3=010 -> never taken
- op=1100111, jalr -> DECODE, JALR (A=10, B=01), JAL (PC_write=1, A=01, B=10), ALU_WB; 5 cycles total. op=1101111, jal -> skips JALR; 4 cycles total.
- op=1111111 -> illegal=1 in DECODE, next state FETCH, and no reg_write or mem_write at any point. op=0110111, lui -> LUI shows result_src=11, imm_src=100, reg_write=1.
